serial_divider: RTL and testbench

Sequential unsigned integer divider for the Hack datapath. It uses restoring division and resolves one quotient bit per clock, so it reuses the subtract path built from the existing adder cells. It sits beside the ALU as a multi-cycle coprocessor. The CPU starts it with a one-cycle START pulse and collects QUOTIENT/REMAINDER when DONE pulses.

---
 rtl/serial_divider_pkg.sv | 16 +
 rtl/serial_divider_step.sv | 24 ++
 rtl/serial_divider.sv | 93 +++++++++
 tb/tb_serial_divider.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_divider_pkg.sv
// Shared definitions for the serial restoring divider: FSM encoding,
// default operand width and the step-counter width helper.
package serial_divider_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } div_state_t;

    localparam int DEFAULT_WIDTH = 16;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_divider_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor through the adder chain, keep or restore.
module serial_divider_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] r,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_next,
    output logic             q_bit
);

    logic [WIDTH:0] t;
    logic [WIDTH:0] s;

    // T - D computed as T + ~D + 1 over WIDTH+1 bits so the borrow lands in s[WIDTH].
    assign t = {r, q_msb};
    assign s = t + {1'b1, ~d} + {{WIDTH{1'b0}}, 1'b1};

    // The kept value is always below D, so its top bit is zero and can be dropped.
    assign q_bit  = ~s[WIDTH];
    assign r_next = s[WIDTH] ? t[WIDTH-1:0] : s[WIDTH-1:0];

endmodule

// File: rtl/serial_divider.sv
// Multi-cycle unsigned divider: one quotient bit per clock, WIDTH+1 cycles
// from accepted START to the DONE pulse; divide-by-zero answers in one cycle.
module serial_divider
    import serial_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] DIVIDEND,
    input  logic [WIDTH-1:0] DIVISOR,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] QUOTIENT,
    output logic [WIDTH-1:0] REMAINDER,
    output logic             DIV_BY_ZERO,
    output div_state_t       dbg_state
);

    localparam int CNT_W = cnt_width(WIDTH);

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] r_next;
    logic             q_bit;

    serial_divider_step #(.WIDTH(WIDTH)) u_step (
        .r      (r),
        .q_msb  (q[WIDTH-1]),
        .d      (d),
        .r_next (r_next),
        .q_bit  (q_bit)
    );

    assign dbg_state = state;

    // Handshake: START is a request taken on any edge where BUSY=0; the matching
    // result is presented with a one-cycle DONE, and START seen while BUSY=1 is dropped.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            cnt         <= '0;
            r           <= '0;
            q           <= '0;
            d           <= '0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            QUOTIENT    <= '0;
            REMAINDER   <= '0;
            DIV_BY_ZERO <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        if (DIVISOR == '0) begin
                            QUOTIENT    <= '1;
                            REMAINDER   <= DIVIDEND;
                            DIV_BY_ZERO <= 1'b1;
                            DONE        <= 1'b1;
                        end else begin
                            r     <= '0;
                            q     <= DIVIDEND;
                            d     <= DIVISOR;
                            cnt   <= '0;
                            BUSY  <= 1'b1;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r   <= r_next;
                    q   <= {q[WIDTH-2:0], q_bit};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        QUOTIENT    <= {q[WIDTH-2:0], q_bit};
                        REMAINDER   <= r_next;
                        DIV_BY_ZERO <= 1'b0;
                        DONE        <= 1'b1;
                        BUSY        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_divider.sv
// Directed bench for serial_divider: latency, BUSY length, results, divide-by-zero,
// ignored START, mid-run reset and back-to-back operation.
module tb_serial_divider;
    import serial_divider_pkg::*;

    localparam int W = 16;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    div_state_t   dbg_state;

    logic [2*W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    serial_divider #(.WIDTH(W)) dut (
        .CLK         (clk),
        .RESET       (reset),
        .START       (start),
        .DIVIDEND    (dividend),
        .DIVISOR     (divisor),
        .BUSY        (busy),
        .DONE        (done),
        .QUOTIENT    (quotient),
        .REMAINDER   (remainder),
        .DIV_BY_ZERO (div_by_zero),
        .dbg_state   (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Caller sits #1 after an edge; START is sampled at the next edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        step();
        start    = 1'b0;
    endtask

    // Returns cycles from the START edge to the DONE cycle, BUSY cycles seen,
    // and whether QUOTIENT/REMAINDER held their entry values until DONE.
    task automatic wait_done(input int inj, output int lat, output int busy_cnt, output bit held);
        logic [W-1:0] q0, r0;
        q0 = quotient;
        r0 = remainder;
        lat = 1;
        busy_cnt = 0;
        held = 1'b1;
        while (!done && lat < 40) begin
            if (quotient !== q0 || remainder !== r0) held = 1'b0;
            if (busy) busy_cnt++;
            if (inj != 0 && busy_cnt == inj && busy) begin
                start    = 1'b1;
                dividend = 16'd9;
                divisor  = 16'd3;
            end else begin
                start = 1'b0;
            end
            step();
            lat++;
        end
        start = 1'b0;
    endtask

    // Scoreboard: compare presented result against the oldest expectation.
    task automatic check_result(input string tag, input logic exp_dbz);
        logic [2*W-1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_quot"}, 32'(quotient), 32'(e[2*W-1:W]));
            check({tag, "_rem"}, 32'(remainder), 32'(e[W-1:0]));
            check({tag, "_dbz"}, 32'(div_by_zero), 32'(exp_dbz));
        end
    endtask

    task automatic run_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er);
        int lat, bc;
        bit held;
        exp_q.push_back({eq, er});
        launch(a, b);
        wait_done(0, lat, bc, held);
        check({tag, "_done"}, 32'(done), 32'd1);
        check_result(tag, 1'b0);
        step();
        check({tag, "_done_width"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat, bc, ndone;
        bit held;
        reset = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        step();
        step();
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quot", 32'(quotient), 32'd0);
        check("rst_rem", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));

        // 100 / 7 with timing
        exp_q.push_back({16'd14, 16'd2});
        launch(16'd100, 16'd7);
        check("run_state", 32'(dbg_state), 32'(RUN));
        wait_done(0, lat, bc, held);
        check("d100_latency", 32'(lat), 32'd17);
        check("d100_busy_cycles", 32'(bc), 32'd16);
        check("d100_busy_at_done", 32'(busy), 32'd0);
        check_result("d100", 1'b0);
        step();
        check("d100_done_width", 32'(done), 32'd0);

        run_one("ffff_1", 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000);
        run_one("ffff_8000", 16'hFFFF, 16'h8000, 16'h0001, 16'h7FFF);

        // 5 / 0
        exp_q.push_back({16'hFFFF, 16'd5});
        launch(16'd5, 16'd0);
        wait_done(0, lat, bc, held);
        check("dz_latency", 32'(lat), 32'd1);
        check("dz_busy_cycles", 32'(bc), 32'd0);
        check("dz_busy", 32'(busy), 32'd0);
        check_result("dz", 1'b1);
        step();
        check("dz_done_width", 32'(done), 32'd0);
        check("dz_busy_after", 32'(busy), 32'd0);

        run_one("d3_10", 16'd3, 16'd10, 16'd0, 16'd3);
        run_one("d0_9", 16'd0, 16'd9, 16'd0, 16'd0);

        // 1000 / 10 with an ignored START (9/3) on the 5th BUSY cycle
        exp_q.push_back({16'd100, 16'd0});
        launch(16'd1000, 16'd10);
        wait_done(5, lat, bc, held);
        check("ign_latency", 32'(lat), 32'd17);
        check_result("ign", 1'b0);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done) ndone++;
        end
        check("ign_extra_done", 32'(ndone), 32'd0);
        check("ign_busy_after", 32'(busy), 32'd0);

        // Reset during step 8 of 40000 / 3
        launch(16'd40000, 16'd3);
        repeat (7) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_quot", 32'(quotient), 32'd0);
        check("mrst_rem", 32'(remainder), 32'd0);
        check("mrst_dbz", 32'(div_by_zero), 32'd0);
        check("mrst_state", 32'(dbg_state), 32'(IDLE));
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done) ndone++;
        end
        check("mrst_no_done", 32'(ndone), 32'd0);
        run_one("d40000_3", 16'd40000, 16'd3, 16'd13333, 16'd1);

        // Back-to-back: 50/6, then 7/7 issued in the DONE cycle
        exp_q.push_back({16'd8, 16'd2});
        launch(16'd50, 16'd6);
        wait_done(0, lat, bc, held);
        check("b2b1_latency", 32'(lat), 32'd17);
        check_result("b2b1", 1'b0);
        exp_q.push_back({16'd1, 16'd0});
        launch(16'd7, 16'd7);
        check("b2b2_accepted", 32'(busy), 32'd1);
        wait_done(0, lat, bc, held);
        check("b2b2_latency", 32'(lat), 32'd17);
        check("b2b_hold", 32'(held), 32'd1);
        check_result("b2b2", 1'b0);
        step();
        check("b2b2_done_width", 32'(done), 32'd0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
